// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the memory port arbiter: data access types, arbiter states
// and the instruction returned when a fetch is abandoned.
package rv32_mem_pkg;

    localparam logic [2:0] DM_B  = 3'b000;
    localparam logic [2:0] DM_H  = 3'b001;
    localparam logic [2:0] DM_W  = 3'b010;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DM_ACC = 2'd1,
        IF_ACC = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus between the arbiter (master) and the BRAM (slave).
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    // Handshake: the master raises MemValid with MemWe/MemBe/MemAddr/MemWData and
    // holds all of them stable until a cycle where MemReady=1; that cycle completes
    // the transfer, and for reads MemRData is valid in that same cycle only.
    logic              MemValid;
    logic              MemWe;
    logic [3:0]        MemBe;
    logic [ADDR_W-1:0] MemAddr;
    logic [31:0]       MemWData;
    logic              MemReady;
    logic [31:0]       MemRData;

    modport master (
        output MemValid, MemWe, MemBe, MemAddr, MemWData,
        input  MemReady, MemRData
    );

    modport slave (
        input  MemValid, MemWe, MemBe, MemAddr, MemWData,
        output MemReady, MemRData
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for data accesses: store placement and byte enables,
// load extraction with sign/zero extension, and illegal/misaligned detection.
module mem_lane_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wplaced,
    output logic [31:0] rdata,
    output logic        err
);
    logic [31:0] shifted;

    assign shifted = rword >> {addr_lo, 3'b000};

    always_comb begin
        be      = 4'b1111;
        wplaced = wdata;
        rdata   = 32'h0;
        err     = 1'b0;
        case (ctrl)
            DM_B, DM_BU: begin
                be      = 4'b0001 << addr_lo;
                wplaced = {4{wdata[7:0]}};
                rdata   = (ctrl == DM_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                         : {24'h0, shifted[7:0]};
            end
            DM_H, DM_HU: begin
                be      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wplaced = {2{wdata[15:0]}};
                rdata   = (ctrl == DM_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                         : {16'h0, shifted[15:0]};
                err     = addr_lo[0];
            end
            DM_W: begin
                rdata = rword;
                err   = (addr_lo != 2'b00);
            end
            default: begin
                be  = 4'b0000;
                err = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port BRAM between instruction fetch and data access:
// data has priority, each access is one handshake, hung memory is timed out.
module mem_port_arbiter
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               IfReq,
    input  logic [ADDR_W-1:0]  IfAddr,
    output logic [31:0]        IfRData,
    output logic               IfDone,
    input  logic               DMRd,
    input  logic               DMWr,
    input  logic [2:0]         DMCtrl,
    input  logic [ADDR_W-1:0]  DMAddr,
    input  logic [31:0]        DMWData,
    output logic [31:0]        DMRData,
    output logic               DMDone,
    output logic               DMErr,
    mem_port_arbiter_if.master mem,
    output arb_state_t         state_dbg
);
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ctrl_q;
    logic [1:0]       alo_q;
    logic             timeout_hit;
    logic [2:0]       al_ctrl;
    logic [1:0]       al_lo;
    logic [3:0]       al_be;
    logic [31:0]      al_wdata;
    logic [31:0]      al_rdata;
    logic             al_err;
    logic             unused_ifaddr_lo;

    assign unused_ifaddr_lo = ^IfAddr[1:0];
    assign state_dbg        = state;
    assign timeout_hit      = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    // Live request steers the aligner in IDLE; the latched one during the access.
    assign al_ctrl = (state == IDLE) ? DMCtrl      : ctrl_q;
    assign al_lo   = (state == IDLE) ? DMAddr[1:0] : alo_q;

    mem_lane_align u_align (
        .ctrl    (al_ctrl),
        .addr_lo (al_lo),
        .wdata   (DMWData),
        .rword   (mem.MemRData),
        .be      (al_be),
        .wplaced (al_wdata),
        .rdata   (al_rdata),
        .err     (al_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            ctrl_q       <= 3'b000;
            alo_q        <= 2'b00;
            IfRData      <= 32'h0;
            IfDone       <= 1'b0;
            DMRData      <= 32'h0;
            DMDone       <= 1'b0;
            DMErr        <= 1'b0;
            mem.MemValid <= 1'b0;
            mem.MemWe    <= 1'b0;
            mem.MemBe    <= 4'b0000;
            mem.MemAddr  <= '0;
            mem.MemWData <= 32'h0;
        end else begin
            IfDone <= 1'b0;
            DMDone <= 1'b0;
            DMErr  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (DMRd || DMWr) begin
                        ctrl_q <= DMCtrl;
                        alo_q  <= DMAddr[1:0];
                        if (al_err) begin
                            DMDone  <= 1'b1;
                            DMErr   <= 1'b1;
                            DMRData <= 32'h0;
                            state   <= RESP;
                        end else begin
                            mem.MemValid <= 1'b1;
                            mem.MemWe    <= DMWr;
                            mem.MemBe    <= DMWr ? al_be : 4'b1111;
                            mem.MemAddr  <= {DMAddr[ADDR_W-1:2], 2'b00};
                            mem.MemWData <= DMWr ? al_wdata : 32'h0;
                            state        <= DM_ACC;
                        end
                    end else if (IfReq) begin
                        mem.MemValid <= 1'b1;
                        mem.MemWe    <= 1'b0;
                        mem.MemBe    <= 4'b1111;
                        mem.MemAddr  <= {IfAddr[ADDR_W-1:2], 2'b00};
                        mem.MemWData <= 32'h0;
                        state        <= IF_ACC;
                    end
                end
                DM_ACC, IF_ACC: begin
                    if (mem.MemReady || timeout_hit) begin
                        mem.MemValid <= 1'b0;
                        mem.MemWe    <= 1'b0;
                        state        <= RESP;
                        if (state == DM_ACC) begin
                            DMDone  <= 1'b1;
                            DMErr   <= !mem.MemReady;
                            DMRData <= (mem.MemReady && !mem.MemWe) ? al_rdata : 32'h0;
                        end else begin
                            IfDone  <= 1'b1;
                            IfRData <= mem.MemReady ? mem.MemRData : NOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: table of data accesses against a small
// BRAM model, then priority, timeout and asynchronous-reset sequences.
module tb_mem_port_arbiter;
  import rv32_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        IfReq = 1'b0;
  logic [31:0] IfAddr = 32'h0;
  logic [31:0] IfRData;
  logic        IfDone;
  logic        DMRd = 1'b0;
  logic        DMWr = 1'b0;
  logic [2:0]  DMCtrl = 3'b000;
  logic [31:0] DMAddr = 32'h0;
  logic [31:0] DMWData = 32'h0;
  logic [31:0] DMRData;
  logic        DMDone;
  logic        DMErr;
  arb_state_t  state_dbg;

  logic        mem_ready = 1'b1;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'h0;
  logic [31:0] poke_data = 32'h0;
  logic [31:0] mem_arr [256];

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_W(32)) mif ();

  mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .IfReq(IfReq), .IfAddr(IfAddr), .IfRData(IfRData), .IfDone(IfDone),
    .DMRd(DMRd), .DMWr(DMWr), .DMCtrl(DMCtrl), .DMAddr(DMAddr), .DMWData(DMWData),
    .DMRData(DMRData), .DMDone(DMDone), .DMErr(DMErr),
    .mem(mif), .state_dbg(state_dbg)
  );

  // clock / memory model
  always #5 clk = ~clk;

  assign mif.MemReady = mem_ready;
  assign mif.MemRData = mem_arr[mif.MemAddr[9:2]];

  always @(posedge clk) begin
    if (poke_en) mem_arr[poke_idx] <= poke_data;
    else if (mif.MemValid && mif.MemReady && mif.MemWe)
      for (int b = 0; b < 4; b++)
        if (mif.MemBe[b]) mem_arr[mif.MemAddr[9:2]][8*b +: 8] <= mif.MemWData[8*b +: 8];
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic poke(input logic [7:0] idx, input logic [31:0] data);
    poke_en = 1'b1; poke_idx = idx; poke_data = data;
    tick();
    poke_en = 1'b0;
  endtask

  // driver: one data request issued in IDLE, held until DMDone
  task automatic do_dm(input logic st, input logic rd, input logic [2:0] ctrl,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output logic [3:0] be,
                       output logic [31:0] mwd, output logic seen, output int cyc);
    rdata = 32'h0; err = 1'b0; be = 4'h0; mwd = 32'h0; seen = 1'b0; cyc = 0;
    DMWr = st; DMRd = rd; DMCtrl = ctrl; DMAddr = addr; DMWData = wdata;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mif.MemValid) begin seen = 1'b1; be = mif.MemBe; mwd = mif.MemWData; end
      if (DMDone) begin cyc = i; rdata = DMRData; err = DMErr; break; end
    end
    DMWr = 1'b0; DMRd = 1'b0;
    tick();
  endtask

  typedef struct {
    string       name;
    logic        st;
    logic        rd;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] pre_word;
    logic [3:0]  exp_be;
    logic [31:0] exp_mwd;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rdata, mwd;
    logic        err, seen;
    logic [3:0]  be;
    int          cyc, dm_cyc, if_cyc, mv_cyc, done_cnt;
    logic [31:0] if_data;

    //            name         st rd ctrl    addr      wdata         pre pre_word      be    mwd           rdata         err
    vecs.push_back('{"sw_word",   1, 0, DM_W,  32'h100, 32'hDEADBEEF, 0, 32'h0,        4'hF, 32'hDEADBEEF, 32'h0,        0});
    vecs.push_back('{"sb_lane3",  1, 0, DM_B,  32'h103, 32'h000000A5, 0, 32'h0,        4'h8, 32'hA5A5A5A5, 32'h0,        0});
    vecs.push_back('{"lb_lane3",  0, 1, DM_B,  32'h103, 32'h0,        1, 32'hA5000000, 4'hF, 32'h0,        32'hFFFFFFA5, 0});
    vecs.push_back('{"lbu_lane3", 0, 1, DM_BU, 32'h103, 32'h0,        1, 32'hA5000000, 4'hF, 32'h0,        32'h000000A5, 0});
    vecs.push_back('{"lhu_hi",    0, 1, DM_HU, 32'h102, 32'h0,        1, 32'h80011234, 4'hF, 32'h0,        32'h00008001, 0});
    vecs.push_back('{"lh_hi",     0, 1, DM_H,  32'h102, 32'h0,        1, 32'h80011234, 4'hF, 32'h0,        32'hFFFF8001, 0});
    vecs.push_back('{"lh_lo",     0, 1, DM_H,  32'h100, 32'h0,        1, 32'h80011234, 4'hF, 32'h0,        32'h00001234, 0});
    vecs.push_back('{"lb_lane1",  0, 1, DM_B,  32'h101, 32'h0,        1, 32'h12348034, 4'hF, 32'h0,        32'hFFFFFF80, 0});
    vecs.push_back('{"lbu_lane0", 0, 1, DM_BU, 32'h100, 32'h0,        1, 32'h123480F0, 4'hF, 32'h0,        32'h000000F0, 0});
    vecs.push_back('{"sh_hi",     1, 0, DM_H,  32'h206, 32'hCAFEBABE, 1, 32'h0,        4'hC, 32'hBABEBABE, 32'h0,        0});
    vecs.push_back('{"sh_lo",     1, 0, DM_H,  32'h204, 32'h0000BEEF, 0, 32'h0,        4'h3, 32'hBEEFBEEF, 32'h0,        0});
    vecs.push_back('{"sw_rd_wr",  1, 1, DM_W,  32'h208, 32'h11223344, 0, 32'h0,        4'hF, 32'h11223344, 32'h0,        0});
    vecs.push_back('{"lw_back",   0, 1, DM_W,  32'h208, 32'h0,        0, 32'h0,        4'hF, 32'h0,        32'h11223344, 0});
    vecs.push_back('{"sb_lane0",  1, 0, DM_B,  32'h200, 32'h12345678, 0, 32'h0,        4'h1, 32'h78787878, 32'h0,        0});
    vecs.push_back('{"lw_mis",    0, 1, DM_W,  32'h102, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1});
    vecs.push_back('{"lh_mis",    0, 1, DM_H,  32'h101, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1});
    vecs.push_back('{"ld_ctrl011",0, 1, 3'b011,32'h100, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1});
    vecs.push_back('{"st_ctrl110",1, 0, 3'b110,32'h100, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1});
    vecs.push_back('{"sw_mis",    1, 0, DM_W,  32'h206, 32'h0,        0, 32'h0,        4'h0, 32'h0,        32'h0,        1});

    // reset state
    tick(); tick();
    check("rst.memvalid", {31'h0, mif.MemValid}, 32'h0);
    check("rst.memwe",    {31'h0, mif.MemWe}, 32'h0);
    check("rst.membe",    {28'h0, mif.MemBe}, 32'h0);
    check("rst.memaddr",  mif.MemAddr, 32'h0);
    check("rst.dones",    {30'h0, IfDone, DMDone}, 32'h0);
    check("rst.rdata",    IfRData | DMRData, 32'h0);
    rst = 1'b0;
    tick();
    check("rst.state", 32'(state_dbg), 32'(IDLE));

    // table of data accesses, MemReady tied high
    foreach (vecs[k]) begin
      if (vecs[k].pre) poke(vecs[k].addr[9:2], vecs[k].pre_word);
      do_dm(vecs[k].st, vecs[k].rd, vecs[k].ctrl, vecs[k].addr, vecs[k].wdata,
            rdata, err, be, mwd, seen, cyc);
      check({vecs[k].name, ".err"},     {31'h0, err},  {31'h0, vecs[k].exp_err});
      check({vecs[k].name, ".rdata"},   rdata,         vecs[k].exp_rdata);
      check({vecs[k].name, ".memvalid"},{31'h0, seen}, {31'h0, !vecs[k].exp_err});
      check({vecs[k].name, ".latency"}, cyc,           vecs[k].exp_err ? 32'd1 : 32'd2);
      if (!vecs[k].exp_err) check({vecs[k].name, ".be"}, {28'h0, be}, {28'h0, vecs[k].exp_be});
      if (!vecs[k].exp_err && vecs[k].st) check({vecs[k].name, ".mwdata"}, mwd, vecs[k].exp_mwd);
    end
    check("mem.sh_merge", mem_arr[8'h81], 32'hBABEBEEF);

    // fetch and data requested together: data first, fetch 3 cycles later
    poke(8'hC0, 32'hAABBCCDD);
    dm_cyc = 0; if_cyc = 0; if_data = 32'h0;
    IfReq = 1'b1; IfAddr = 32'h300;
    DMRd = 1'b1; DMCtrl = DM_W; DMAddr = 32'h208;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (DMDone && dm_cyc == 0) begin dm_cyc = i; rdata = DMRData; DMRd = 1'b0; end
      if (IfDone && if_cyc == 0) begin if_cyc = i; if_data = IfRData; IfReq = 1'b0; end
      if (dm_cyc != 0 && if_cyc != 0) break;
    end
    IfReq = 1'b0; DMRd = 1'b0;
    tick();
    check("prio.dm_cycle", dm_cyc, 32'd2);
    check("prio.if_cycle", if_cyc, 32'd5);
    check("prio.dm_data",  rdata, 32'h11223344);
    check("prio.if_data",  if_data, 32'hAABBCCDD);

    // fetch timeout: 15 MemValid cycles then NOP
    mem_ready = 1'b0;
    mv_cyc = 0; if_cyc = 0; if_data = 32'h0;
    IfReq = 1'b1; IfAddr = 32'h300;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (mif.MemValid) mv_cyc++;
      if (IfDone) begin if_cyc = i; if_data = IfRData; break; end
    end
    IfReq = 1'b0;
    tick();
    check("if_to.valid_cycles", mv_cyc, 32'd15);
    check("if_to.done_cycle",   if_cyc, 32'd16);
    check("if_to.nop",          if_data, 32'h00000013);

    // store timeout: error, memory untouched
    poke(8'hC1, 32'h55555555);
    do_dm(1'b1, 1'b0, DM_W, 32'h304, 32'hFFFFFFFF, rdata, err, be, mwd, seen, cyc);
    check("dm_to.err",   {31'h0, err}, 32'h1);
    check("dm_to.cycle", cyc, 32'd16);
    check("dm_to.mem",   mem_arr[8'hC1], 32'h55555555);
    mem_ready = 1'b1;

    // asynchronous reset in the middle of a data access
    mem_ready = 1'b0;
    DMRd = 1'b1; DMCtrl = DM_W; DMAddr = 32'h208;
    tick(); tick();
    check("arst.pre_valid", {31'h0, mif.MemValid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("arst.valid_drop", {31'h0, mif.MemValid}, 32'h0);
    check("arst.state",      32'(state_dbg), 32'(IDLE));
    DMRd = 1'b0; mem_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (DMDone || IfDone) done_cnt++;
    end
    check("arst.no_done", done_cnt, 32'd0);

    // normal access still works after the reset
    do_dm(1'b0, 1'b1, DM_W, 32'h208, 32'h0, rdata, err, be, mwd, seen, cyc);
    check("post_rst.rdata", rdata, 32'h11223344);
    check("post_rst.cycle", cyc, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
